running_enemy_sprite_fetch: RTL
===============================

Name: running_enemy_sprite_fetch

Overview:
- Upstream stage of the green running-enemy palette lookup.
- Per VGA pixel, decides whether the pixel lies inside the enemy sprite box and fetches the 3-bit palette index from the sprite-sheet ROM.
- Advances the run-cycle animation once per N video frames.
- Emits a pipelined index plus a valid flag to the palette and colour mux. Index 0 is the chroma-key (transparent) colour.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels (power of 2)
- NUM_FRAMES, 6, animation frames in the sheet
- FRAME_HOLD, 6, video frames each animation frame is held
- ROM_AW, 13, ROM address width; must satisfy 2^ROM_AW >= NUM_FRAMES*SPR_W*SPR_H

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- vsync  in  1  VGA vsync, active low
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- enemy_x  in  10  sprite top-left column
- enemy_y  in  10  sprite top-left row
- enemy_active  in  1  enemy alive and drawn
- facing_left  in  1  enemy direction
- rom_addr  out  ROM_AW  sprite ROM address
- rom_q  in  3  sprite ROM data, one cycle after rom_addr
- pixel_index  out  3  palette index to palette lookup
- pixel_valid  out  1  opaque sprite pixel present

Behaviour:
- Reset: all registers clear asynchronously when Reset_n=0. Values: rom_addr=0, pixel_index=0, pixel_valid=0, anim frame=0, hold count=0, latched position=0, latched active=0, pipeline valid bits=0, vsync history=1.
- Frame tick:
  - One-cycle pulse on the registered falling edge of vsync, i.e. vsync_d=1 and vsync=0.
  - On a tick, latch enemy_x, enemy_y, enemy_active and facing_left into shadow registers. All hit tests use the shadow copies, so the sprite never tears mid-frame.
- Animation counter:
  - On a tick with latched active=1:
    - If hold==FRAME_HOLD-1: hold<=0, and frame<=(frame==NUM_FRAMES-1)?0:frame+1.
    - Otherwise: hold<=hold+1.
  - On a tick with latched active=0: frame<=0, hold<=0, so a respawn always starts at frame 0.
  - No change between ticks.
- Hit test (stage 0, combinational on DrawX/DrawY):
  - Use 11-bit unsigned arithmetic, with no wrap.
  - hit = active_s & (DrawX>=ex_s) & (DrawX<ex_s+SPR_W) & (DrawY>=ey_s) & (DrawY<ey_s+SPR_H).
  - col = DrawX-ex_s and row = DrawY-ey_s, each truncated to log2 width/height.
  - A sprite partly beyond x=639 or y=479 simply clips.
- Pipeline:
  - Cycle t+1: rom_addr <= frame*SPR_W*SPR_H + row*SPR_W + col, and hit_d1<=hit. When hit=0, rom_addr holds its previous value, which is don't-care.
  - Cycle t+2: rom_q is valid; hit_d2<=hit_d1.
  - Output registers update on the Clk edge that ends cycle t+2: pixel_index<=hit_d2?rom_q:0 and pixel_valid<=hit_d2&(rom_q!=0).
  - Outputs are therefore visible in cycle t+3, a fixed 3-cycle latency from DrawX/DrawY. The downstream mux delays its other layers by 3.
- Frame change timing: the frame counter only changes on a tick, which falls during vertical blanking. A ROM read therefore never mixes frames within a visible line.
- Reset mid-line: outputs go to 0 immediately. The first valid output after release appears 3 cycles after the first hit pixel. Shadow registers stay 0, so nothing draws until the next tick.

Optional Feature:
- Macro: ENEMY_MIRROR_EN.
- Defined: when latched facing_left=1, col is replaced by SPR_W-1-col before address formation. The sheet stores right-facing art only.
- Undefined: facing_left is ignored and art is always drawn as stored. The port remains for interface stability.

Test Plan:
- Reset_n=0 for 5 cycles mid-stream -> rom_addr=0, pixel_index=0, pixel_valid=0, frame=0 throughout; after release no valid until a vsync tick with enemy_active=1.
- enemy_x=100, enemy_y=200, active, one tick. Sweep DrawY=200, DrawX=99..132 with the ROM model returning nonzero -> pixel_valid=1 exactly for DrawX 100..131, appearing 3 cycles after each DrawX, and rom_addr for DrawX=100 equals 0.
- Hold active for 36 ticks (FRAME_HOLD=6, NUM_FRAMES=6) -> frame increments at ticks 6, 12, 18, 24, 30 and wraps to 0 at tick 36. DrawY=201, DrawX=100 during frame 1 -> rom_addr=1024+32=1056.
- enemy_x=620, DrawY=ey, DrawX 619..639 -> valid only for DrawX 620..639; no hit when DrawX resets to 0 on the next line.
- ROM returns 0 inside the box -> pixel_index=0, pixel_valid=0. enemy_active dropped with no new tick -> still drawn; after the next tick nothing is drawn and frame=0.
- ENEMY_MIRROR_EN defined, facing_left=1, enemy_x=100, DrawX=100, DrawY=ey, frame 0 -> rom_addr=31; undefined -> rom_addr=0.

Source files
------------

// File: rtl/running_enemy_sprite_fetch.sv
// running_enemy_sprite_fetch
//   Front end of the green running-enemy renderer. For every VGA pixel it
//   decides whether the pixel falls inside the enemy sprite box. It then
//   fetches the 3-bit palette index from the external sprite-sheet ROM and
//   presents it to the palette lookup with a fixed 3-cycle latency. The
//   run-cycle animation advances once every FRAME_HOLD video frames.
//   Palette index 0 is the transparent (chroma-key) colour.
//
// Ports
//   Clk, Reset_n         pixel clock, asynchronous active-low reset
//   vsync                VGA vsync (active low); its falling edge is the frame tick
//   DrawX, DrawY         current pixel column / row
//   enemy_x, enemy_y     sprite top-left corner, sampled on each frame tick
//   enemy_active         enemy alive and drawn, sampled on each frame tick
//   facing_left          enemy direction, sampled on each frame tick
//   rom_addr / rom_q     synchronous sprite ROM; data returns one cycle after the address
//   pixel_index          palette index, 0 when no sprite pixel is present
//   pixel_valid          an opaque sprite pixel is present
//
// Build option
//   ENEMY_MIRROR_EN      when defined, a left-facing enemy is drawn mirrored
//                        horizontally. Otherwise facing_left has no effect.

module running_enemy_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 6,
  parameter int FRAME_HOLD = 6,
  parameter int ROM_AW     = 13
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vsync,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        enemy_x,
  input  logic [9:0]        enemy_y,
  input  logic              enemy_active,
  input  logic              facing_left,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [2:0]        rom_q,
  output logic [2:0]        pixel_index,
  output logic              pixel_valid
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [ROM_AW-1:0] FRAME_SZ = ROM_AW'(SPR_W * SPR_H);

  logic              vsync_q;
  logic [9:0]        ex_q, ey_q;
  logic              active_q, left_q;
  logic [FW-1:0]     frame_q, frame_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d2_q;
  logic [2:0]        pixel_index_q;
  logic              pixel_valid_q;

  logic              tick;
  logic              hit;
  logic [10:0]       x11, y11, ex11, ey11;
  logic [CW-1:0]     col, col_m;
  logic [RW-1:0]     row;

  // Frame tick: the registered falling edge of vsync. It always lands in
  // vertical blanking, so the shadow state never changes mid-picture.
  assign tick = vsync_q & ~vsync;

  // Animation next state. The active flag used here is the one being latched
  // on this same tick. As a result, a respawned enemy always restarts at frame 0.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    frame_d = frame_q;
    hold_d  = hold_q;
    if (tick) begin
      if (enemy_active) begin
        if (hold_q == HW'(FRAME_HOLD - 1)) begin
          hold_d  = '0;
          frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end else begin
        frame_d = '0;
        hold_d  = '0;
      end
    end
  end

  // Stage 0 hit test. The 11-bit compares keep ex+SPR_W from wrapping, so a
  // sprite that runs off the right or bottom edge simply clips.
  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign ex11 = {1'b0, ex_q};
  assign ey11 = {1'b0, ey_q};

  assign hit = active_q
             & (x11 >= ex11) & (x11 < ex11 + 11'(SPR_W))
             & (y11 >= ey11) & (y11 < ey11 + 11'(SPR_H));

  // Inside the box the offset is below the power-of-two size. Subtracting
  // only the low bits therefore gives the same result as truncating the
  // full difference.
  assign col = DrawX[CW-1:0] - ex_q[CW-1:0];
  assign row = DrawY[RW-1:0] - ey_q[RW-1:0];

`ifdef ENEMY_MIRROR_EN
  // The sheet holds right-facing art only; left-facing reads columns reversed.
  assign col_m = left_q ? (CW'(SPR_W - 1) - col) : col;
`else
  logic unused_left;
  assign unused_left = left_q;
  assign col_m       = col;
`endif

  // Frame base plus {row, col}. {row, col} equals row*SPR_W + col because
  // SPR_W is a power of two. Off-sprite pixels keep the previous address,
  // which the pipeline ignores.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit) begin
      rom_addr_d = (ROM_AW'(frame_q) * FRAME_SZ) + ROM_AW'({row, col_m});
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, and the pipeline stages shift
  // in lockstep.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vsync_q       <= 1'b1;
      ex_q          <= '0;
      ey_q          <= '0;
      active_q      <= 1'b0;
      left_q        <= 1'b0;
      frame_q       <= '0;
      hold_q        <= '0;
      rom_addr_q    <= '0;
      hit_d1_q      <= 1'b0;
      hit_d2_q      <= 1'b0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (tick) begin
        ex_q     <= enemy_x;
        ey_q     <= enemy_y;
        active_q <= enemy_active;
        left_q   <= facing_left;
      end
      frame_q       <= frame_d;
      hold_q        <= hold_d;
      rom_addr_q    <= rom_addr_d;
      hit_d1_q      <= hit;
      hit_d2_q      <= hit_d1_q;
      pixel_index_q <= hit_d2_q ? rom_q : 3'd0;
      pixel_valid_q <= hit_d2_q & (rom_q != 3'd0);
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pixel_index = pixel_index_q;
  assign pixel_valid = pixel_valid_q;

endmodule
